// File: rtl/pool_max2x2_if.sv
// pool_max2x2_if -- stream bundle for the 2x2 max-pool block.
//   in_valid/in_ready/in_data     : raster-order conv results into the pool
//   out_valid/out_ready/out_data  : pooled results out of the pool
//   frame_done                    : one-cycle pulse on the last pooled transfer
// Modports: slave = pooling block side, master = producer/consumer side.
interface pool_max2x2_if #(
  parameter int DATA_W = 25
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              frame_done;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, frame_done
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, frame_done
  );
endinterface

// File: rtl/pool_max2x2.sv
// pool_max2x2 -- streaming 2x2 / stride-2 max pooling over a raster-order
// feature map of unsigned conv results.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   map_width, map_height  : frame dimensions, latched on pixel (0,0)
//   bus (slave)            : in_* stream, out_* stream, frame_done pulse
// Optional build macro: POOL_SAT8_EN -- saturate out_data to 255.
// Odd widths/heights drop the trailing column/row without output.
module pool_max2x2 #(
  parameter int DATA_W = 25,
  parameter int MAX_W  = 64,
  parameter int DIM_W  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIM_W-1:0] map_width,
  input  logic [DIM_W-1:0] map_height,
  pool_max2x2_if.slave     bus
);

  localparam int LB_N  = MAX_W / 2;
  localparam int IDX_W = (LB_N > 1) ? $clog2(LB_N) : 1;

  logic [DIM_W-1:0]  col, row, w_lat, h_lat;
  logic [DIM_W-1:0]  w_eff, h_eff, w_pair_last, h_pair_last;
  logic              first, accept, last_col, last_row, pair_beat, load;
  logic              in_ready;
  logic [DATA_W-1:0] prev, pair_max, lb_rd, win_max, res;
  logic [IDX_W-1:0]  lb_idx;
  logic [DATA_W-1:0] lbuf [LB_N];

  logic              out_valid_q, out_last_q;
  logic [DATA_W-1:0] out_data_q;

  // Ready only depends on the output register, never on in_valid.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // On pixel (0,0) the live dimension ports apply, as they are latched now.
  assign first = (col == '0) && (row == '0);
  assign w_eff = first ? map_width  : w_lat;
  assign h_eff = first ? map_height : h_lat;

  assign last_col = (col == w_eff - DIM_W'(1));
  assign last_row = (row == h_eff - DIM_W'(1));

  // Coordinates of the final complete window (odd dimensions rounded down).
  assign w_pair_last = {w_eff[DIM_W-1:1], 1'b0} - DIM_W'(1);
  assign h_pair_last = {h_eff[DIM_W-1:1], 1'b0} - DIM_W'(1);

  assign lb_idx    = IDX_W'(col >> 1);
  assign pair_beat = accept && col[0];
  assign load      = pair_beat && row[0];

  assign pair_max = (bus.in_data > prev) ? bus.in_data : prev;
  assign lb_rd    = lbuf[lb_idx];
  assign win_max  = (pair_max > lb_rd) ? pair_max : lb_rd;

  always_comb begin
    res = win_max;
`ifdef POOL_SAT8_EN
    if (|win_max[DATA_W-1:8]) res = DATA_W'(8'hFF);
`endif
  end

  // Raster position, latched dimensions and the even-column pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col   <= '0;
      row   <= '0;
      w_lat <= '0;
      h_lat <= '0;
      prev  <= '0;
    end else if (accept) begin
      if (first) begin
        w_lat <= map_width;
        h_lat <= map_height;
      end
      if (!col[0]) prev <= bus.in_data;
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + DIM_W'(1);
      end else begin
        col <= col + DIM_W'(1);
      end
    end
  end

  // Line buffer of horizontal pair maxima from the even row; no reset needed.
  always_ff @(posedge clk) begin
    if (pair_beat && !row[0]) lbuf[lb_idx] <= pair_max;
  end

  // Output register: a load only happens when in_ready was high, so it
  // either fills an empty slot or replaces a result leaving this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= res;
      out_last_q  <= (row == h_pair_last) && (col == w_pair_last);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.frame_done = out_valid_q && bus.out_ready && out_last_q;

endmodule

// File: tb/tb_pool_max2x2.sv
// tb_pool_max2x2 -- directed bench for pool_max2x2 with hand-computed results.
module tb_pool_max2x2;
  localparam int DW   = 25;
  localparam int MW   = 64;
  localparam int DIMW = 7;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [DIMW-1:0] map_w, map_h;

  pool_max2x2_if #(.DATA_W(DW)) bus ();

  pool_max2x2 #(.DATA_W(DW), .MAX_W(MW), .DIM_W(DIMW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .map_width  (map_w),
    .map_height (map_h),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  logic [DW-1:0] outs[$];
  int unsigned   out_cyc[$];
  bit            fds[$];
  int unsigned   acc_cyc[$];
  logic [DW-1:0] pix[$];
  int unsigned   stalls = 0;
  int unsigned   stray_fd = 0;

  // Observe at the falling edge: what is seen here transfers on the next rise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        outs.push_back(bus.out_data);
        out_cyc.push_back(cyc);
        fds.push_back(bus.frame_done);
      end else if (bus.frame_done) begin
        stray_fd++;
      end
      if (bus.in_valid && !bus.in_ready) stalls++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int unsigned n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        done = 1'b1;
        acc_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame();
    for (int i = 0; i < pix.size(); i++) push(pix[i]);
  endtask

  task automatic clear();
    outs.delete();
    out_cyc.delete();
    fds.delete();
    acc_cyc.delete();
    pix.delete();
  endtask

  function automatic logic [31:0] out_at(input int k);
    if (k < outs.size()) return 32'(outs[k]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int unsigned fd_sum();
    int unsigned s = 0;
    for (int i = 0; i < fds.size(); i++) s += 32'(fds[i]);
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp4 [4];
    int          idx4 [4];
    bit          seen;
    logic [31:0] sat_exp;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    map_w = '0;
    map_h = '0;
    tick(3);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    tick(2);

    // 4x4 ramp, free-flowing output
    clear();
    map_w = 7'd4; map_h = 7'd4;
    for (int i = 0; i < 16; i++) pix.push_back(DW'(i));
    send_frame();
    tick(3);
    exp4 = '{5, 7, 13, 15};
    idx4 = '{5, 7, 13, 15};
    chk("ramp_count", outs.size(), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ramp_val%0d", k), out_at(k), exp4[k]);
      if (k < out_cyc.size() && idx4[k] < acc_cyc.size())
        chk($sformatf("ramp_lat%0d", k), out_cyc[k] - acc_cyc[idx4[k]], 32'd1);
      else
        chk($sformatf("ramp_lat%0d", k), 32'd0, 32'd1);
      chk($sformatf("ramp_fd%0d", k), (k < fds.size()) ? 32'(fds[k]) : 32'd9,
          (k == 3) ? 32'd1 : 32'd0);
    end

    // Same frame, backpressure while the first result is pending
    clear();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) pix.push_back(DW'(i));
    fork
      send_frame();
      begin
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
          @(negedge clk);
          if (bus.out_valid) seen = 1'b1;
        end
        chk("bp_seen_valid", 32'(seen), 32'd1);
        repeat (4) @(negedge clk);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_out_hold", 32'(bus.out_data), 32'd5);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    tick(3);
    chk("bp_accepted", acc_cyc.size(), 32'd16);
    chk("bp_count", outs.size(), 32'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("bp_val%0d", k), out_at(k), exp4[k]);

    // 5x3 with a single peak; column 4 and row 2 produce nothing
    clear();
    map_w = 7'd5; map_h = 7'd3;
    for (int i = 0; i < 15; i++) pix.push_back((i == 6) ? DW'(40) : DW'(9));
    send_frame();
    tick(3);
    chk("odd_count", outs.size(), 32'd2);
    chk("odd_val0", out_at(0), 32'd40);
    chk("odd_val1", out_at(1), 32'd9);
    chk("odd_fd", fd_sum(), 32'd1);

    // Reset mid-frame, then a fresh 4x2 frame
    clear();
    map_w = 7'd4; map_h = 7'd4;
    push(DW'(100));
    push(DW'(200));
    rst_n = 1'b0;
    tick(2);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    tick(1);
    map_w = 7'd4; map_h = 7'd2;
    for (int i = 1; i <= 8; i++) pix.push_back(DW'(i));
    send_frame();
    tick(3);
    chk("rst_frame_count", outs.size(), 32'd2);
    chk("rst_frame_val0", out_at(0), 32'd6);
    chk("rst_frame_val1", out_at(1), 32'd8);
    chk("rst_frame_fd", fd_sum(), 32'd1);

    // Large value: saturated or full width depending on build
    clear();
    map_w = 7'd2; map_h = 7'd2;
    pix.push_back(DW'(1000)); pix.push_back(DW'(3));
    pix.push_back(DW'(4));    pix.push_back(DW'(5));
    send_frame();
    tick(3);
`ifdef POOL_SAT8_EN
    sat_exp = 32'd255;
`else
    sat_exp = 32'd1000;
`endif
    chk("big_val", out_at(0), sat_exp);

    // Two back-to-back 2x2 frames, no stalls
    clear();
    stalls = 0;
    pix.push_back(DW'(1)); pix.push_back(DW'(2)); pix.push_back(DW'(3)); pix.push_back(DW'(4));
    pix.push_back(DW'(8)); pix.push_back(DW'(7)); pix.push_back(DW'(6)); pix.push_back(DW'(5));
    send_frame();
    tick(3);
    chk("b2b_count", outs.size(), 32'd2);
    chk("b2b_val0", out_at(0), 32'd4);
    chk("b2b_val1", out_at(1), 32'd8);
    chk("b2b_fd", fd_sum(), 32'd2);
    chk("b2b_stalls", stalls, 32'd0);
    chk("b2b_span", (acc_cyc.size() == 8) ? acc_cyc[7] - acc_cyc[0] : 32'd0, 32'd7);
    chk("stray_frame_done", stray_fd, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pool_max2x2.md
POOL_MAX2X2 -- requirements
Module: pool_max2x2

Interface
REQ-001 Parameter DATA_W, default 25, SHALL set the width of conv results in and pooled results out.
REQ-002 Parameter MAX_W, default 64, SHALL set the maximum feature-map width in pixels, even, at least 2.
REQ-003 Parameter DIM_W, default 7, SHALL set the width of the map_width and map_height ports.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL flag that in_data holds one conv result, delivered in raster order.
REQ-007 in_ready  output  1  SHALL flag that the block accepts in_data this cycle.
REQ-008 in_data  input  DATA_W  SHALL carry a conv result, unsigned, already clamped to be non-negative.
REQ-009 map_width  input  DIM_W  SHALL give the feature-map width W, 2..MAX_W.
REQ-010 map_height  input  DIM_W  SHALL give the feature-map height H, at least 2.
REQ-011 out_valid  output  1  SHALL flag that out_data holds one pooled result.
REQ-012 out_ready  input  1  SHALL flag that the downstream stage accepts out_data.
REQ-013 out_data  output  DATA_W  SHALL carry the max of one 2x2 window.
REQ-014 frame_done  output  1  SHALL pulse for one cycle when the last pooled result of a frame is accepted.

Function
REQ-015 A beat SHALL transfer when in_valid and in_ready are both high; the same rule SHALL apply to out_valid and out_ready.
REQ-016 in_ready SHALL equal (!out_valid || out_ready) and SHALL NOT depend combinationally on in_valid.
REQ-017 map_width and map_height SHALL be latched on the first accepted beat of a frame (col=0, row=0) and held until the frame ends.
REQ-018 Column and row counters SHALL advance per accepted beat; col SHALL wrap to 0 after W-1 and row SHALL increment on that wrap.
REQ-019 On even rows, at odd col, the block SHALL write max(previous pixel, current pixel) into line-buffer entry col>>1; the line buffer holds MAX_W/2 entries.
REQ-020 On odd rows, at odd col, the block SHALL load out_data = max(pair max, buffer[col>>1]) and assert out_valid on the next cycle (latency 1).
REQ-021 Odd W SHALL be handled by accepting and discarding the last pixel of each row; odd H SHALL be handled by accepting and discarding the last row, which produces no output.
REQ-022 out_valid SHALL stay high with out_data stable until accepted; a new result and acceptance of the old one in the same cycle SHALL overwrite without a bubble.
REQ-023 After the final beat (row=H-1, col=W-1) is accepted, the counters SHALL return to 0 and the next beat SHALL start a new frame.
REQ-024 frame_done SHALL pulse in the cycle the last pooled result of the frame transfers on the output.
REQ-025 Comparisons SHALL be unsigned over the full DATA_W; on equal inputs either value may be selected.

Reset
REQ-026 While rst_n is low, these SHALL be held: out_valid=0, out_data=0, frame_done=0, counters=0, and the latched dimensions=0.
REQ-027 Line-buffer contents SHALL NOT require reset; reset mid-frame SHALL abandon the frame, and the first beat after release SHALL be pixel (0,0).

Configuration
REQ-028 With POOL_SAT8_EN defined, out_data SHALL be saturated to 255 (bits DATA_W-1..8 zero, low byte 8'hFF whenever the max exceeds 255); without it, out_data SHALL be the full-width max.

Verification
REQ-029 W=4, H=4, pixels 0..15, out_ready=1 -> outputs 5, 7, 13, 15, one cycle after pixels 5, 7, 13, 15 are accepted; frame_done coincides with 15.
REQ-030 Same frame with out_ready held low after the first output -> in_ready low, out_data holds 5, no beat lost; releasing out_ready resumes and yields 7, 13, 15.
REQ-031 W=5, H=3, all pixels 9 except (1,1)=40 -> outputs 40, 9; column 4 and row 2 are consumed without output.
REQ-032 Assert rst_n low after pixel (1,0) of a W=4 frame, then send a full W=4, H=2 frame 1..8 -> outputs 6, 8 only.
REQ-033 Pixel value 1000 in a window: with POOL_SAT8_EN -> 255; without -> 1000.
REQ-034 Two back-to-back W=2, H=2 frames, continuous in_valid and out_ready -> two outputs and two frame_done pulses, with no stall cycles.
